// File: rtl/conv_3x3.sv
// Multi-cycle 3x3 valid-region correlation on signed fixed-point pixels.
// Inputs are captured once after reset; one output pixel is produced per cycle.
module conv_3x3 #(
  parameter int total_bits = 16,
  parameter int frac_bits  = 8,
  parameter int max_rows   = 8,
  parameter int max_cols   = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [3:0]                                      rows,
  input  logic [3:0]                                      cols,
  input  logic [max_rows*max_cols*total_bits-1:0]         matrix_data,
  input  logic [total_bits-1:0]                           K00,
  input  logic [total_bits-1:0]                           K01,
  input  logic [total_bits-1:0]                           K02,
  input  logic [total_bits-1:0]                           K10,
  input  logic [total_bits-1:0]                           K11,
  input  logic [total_bits-1:0]                           K12,
  input  logic [total_bits-1:0]                           K20,
  input  logic [total_bits-1:0]                           K21,
  input  logic [total_bits-1:0]                           K22,
  output logic [(max_rows-2)*(max_cols-2)*total_bits-1:0] filtered_matrix,
  output logic                                            done,
  output logic [1:0]                                      fsm_state
);

  localparam int acc_w = 2 * total_bits + 4;
  localparam logic signed [acc_w-1:0] sat_max = acc_w'((2 ** (total_bits - 1)) - 1);
  localparam logic signed [acc_w-1:0] sat_min = -acc_w'(2 ** (total_bits - 1));

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]                              rows_q;
  logic [3:0]                              cols_q;
  logic [max_rows*max_cols*total_bits-1:0] matrix_q;
  logic signed [total_bits-1:0]            coef_q [9];
  logic [3:0]                              i_q;
  logic [3:0]                              j_q;

  logic size_ok;
  logic last_col;
  logic last_row;
  logic last_pix;

  logic signed [total_bits-1:0]   pix;
  logic signed [2*total_bits-1:0] prod;
  logic signed [acc_w-1:0]        acc;
  logic signed [acc_w-1:0]        shifted;
  logic [total_bits-1:0]          result;
  int                             pix_idx;
  int                             out_idx;

  assign fsm_state = state_q;

  // Size is judged on the live inputs because it is evaluated in the capture cycle.
  assign size_ok = (rows >= 4'd3) && (cols >= 4'd3) &&
                   (int'(rows) <= max_rows) && (int'(cols) <= max_cols);

  assign last_col = (j_q == cols_q - 4'd3);
  assign last_row = (i_q == rows_q - 4'd3);
  assign last_pix = last_col && last_row;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_LOAD;
      S_LOAD:    state_d = size_ok ? S_COMPUTE : S_DONE;
      S_COMPUTE: if (last_pix) state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Window multiply-accumulate for the current (i, j); the accumulator is wide enough for nine full products.
  always_comb begin
    acc     = '0;
    pix     = '0;
    prod    = '0;
    pix_idx = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        pix_idx = (int'(i_q) + r) * max_cols + int'(j_q) + c;
        pix     = matrix_q[pix_idx*total_bits +: total_bits];
        prod    = pix * coef_q[r*3+c];
        acc     = acc + {{(acc_w-2*total_bits){prod[2*total_bits-1]}}, prod};
      end
    end
    shifted = acc >>> frac_bits;
    if (shifted > sat_max)      result = sat_max[total_bits-1:0];
    else if (shifted < sat_min) result = sat_min[total_bits-1:0];
    else                        result = shifted[total_bits-1:0];
    out_idx = int'(i_q) * (int'(cols_q) - 2) + int'(j_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q          <= '0;
      cols_q          <= '0;
      matrix_q        <= '0;
      i_q             <= '0;
      j_q             <= '0;
      done            <= 1'b0;
      filtered_matrix <= '0;
      for (int k = 0; k < 9; k++) coef_q[k] <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          rows_q          <= rows;
          cols_q          <= cols;
          matrix_q        <= matrix_data;
          coef_q[0]       <= K00;
          coef_q[1]       <= K01;
          coef_q[2]       <= K02;
          coef_q[3]       <= K10;
          coef_q[4]       <= K11;
          coef_q[5]       <= K12;
          coef_q[6]       <= K20;
          coef_q[7]       <= K21;
          coef_q[8]       <= K22;
          filtered_matrix <= '0;
          i_q             <= '0;
          j_q             <= '0;
          done            <= !size_ok;
        end
        S_COMPUTE: begin
          filtered_matrix[out_idx*total_bits +: total_bits] <= result;
          if (last_col) begin
            j_q <= '0;
            if (last_pix) done <= 1'b1;
            else          i_q  <= i_q + 4'd1;
          end else begin
            j_q <= j_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_3x3.sv
// Directed and random checks of conv_3x3: reset, latency, arithmetic, saturation,
// input capture, mid-run abort and size errors against a behavioural reference.
module tb_conv_3x3;
  localparam int tw   = 16;
  localparam int mr   = 8;
  localparam int mc   = 8;
  localparam int n_sl = (mr - 2) * (mc - 2);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [3:0]              rows = '0;
  logic [3:0]              cols = '0;
  logic [mr*mc*tw-1:0]     matrix_data = '0;
  logic [tw-1:0]           K00 = '0, K01 = '0, K02 = '0;
  logic [tw-1:0]           K10 = '0, K11 = '0, K12 = '0;
  logic [tw-1:0]           K20 = '0, K21 = '0, K22 = '0;
  logic [n_sl*tw-1:0]      filtered_matrix;
  logic                    done;
  logic [1:0]              fsm_state;

  int          px [mr][mc];
  int          kk [9];
  logic [tw-1:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;

  conv_3x3 dut (
    .clk(clk), .rst(rst), .rows(rows), .cols(cols), .matrix_data(matrix_data),
    .K00(K00), .K01(K01), .K02(K02), .K10(K10), .K11(K11), .K12(K12),
    .K20(K20), .K21(K21), .K22(K22),
    .filtered_matrix(filtered_matrix), .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic apply_inputs(input int r, input int c);
    rows = 4'(r);
    cols = 4'(c);
    for (int y = 0; y < mr; y++)
      for (int x = 0; x < mc; x++)
        matrix_data[(y*mc+x)*tw +: tw] = 16'(px[y][x]);
    K00 = 16'(kk[0]); K01 = 16'(kk[1]); K02 = 16'(kk[2]);
    K10 = 16'(kk[3]); K11 = 16'(kk[4]); K12 = 16'(kk[5]);
    K20 = 16'(kk[6]); K21 = 16'(kk[7]); K22 = 16'(kk[8]);
  endtask

  function automatic logic [15:0] model_pix(input int i, input int j);
    longint a = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        a += longint'(px[i+r][j+c]) * longint'(kk[r*3+c]);
    a = a >>> 8;
    if (a > 32767)  a = 32767;
    if (a < -32768) a = -32768;
    return a[15:0];
  endfunction

  task automatic push_model(input int r, input int c);
    for (int i = 0; i < r - 2; i++)
      for (int j = 0; j < c - 2; j++)
        exp_q.push_back(model_pix(i, j));
  endtask

  task automatic scramble_inputs();
    matrix_data = {18{$urandom()}};
    rows = 4'($urandom_range(3, 8));
    cols = 4'($urandom_range(3, 8));
    K00 = 16'($urandom()); K11 = 16'($urandom()); K22 = 16'($urandom());
  endtask

  task automatic run_case(input string tag, input int r, input int c);
    bit   ok  = (r >= 3) && (c >= 3) && (r <= mr) && (c <= mc);
    int   n   = ok ? (r - 2) * (c - 2) : 0;
    int   lat = n + 2;
    int   cyc = 0;
    logic [15:0] expv;
    logic [15:0] first_exp = '0;
    apply_inputs(r, c);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({tag, " rst_done"}, 16'(done), 16'd0);
    check({tag, " rst_out"}, 16'(filtered_matrix == '0), 16'd1);
    rst = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 2) scramble_inputs();
    end
    check({tag, " latency"}, 16'(cyc), 16'(lat));
    for (int s = 0; s < n_sl; s++) begin
      if (s < n) begin
        if (exp_q.size() == 0) begin
          check({tag, " queue_empty"}, 16'd1, 16'd0);
          expv = '0;
        end else begin
          expv = exp_q.pop_front();
        end
      end else begin
        expv = '0;
      end
      if (s == 0) first_exp = expv;
      check($sformatf("%s slot%0d", tag, s), filtered_matrix[s*tw +: tw], expv);
    end
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold_done"}, 16'(done), 16'd1);
    check({tag, " hold_slot0"}, filtered_matrix[0 +: tw], first_exp);
  endtask

  initial begin
    // 4x4 vertical stripes: odd columns are 1.0, all coefficients 28.
    for (int y = 0; y < mr; y++) for (int x = 0; x < mc; x++) px[y][x] = (x % 2) ? 256 : 0;
    for (int k = 0; k < 9; k++) kk[k] = 28;
    exp_q.push_back(16'd84); exp_q.push_back(16'd168);
    exp_q.push_back(16'd84); exp_q.push_back(16'd168);
    run_case("stripes4x4", 4, 4);

    for (int y = 0; y < mr; y++) for (int x = 0; x < mc; x++) px[y][x] = ((y + x) % 2) ? 256 : 0;
    push_model(8, 8);
    run_case("checker_k28", 8, 8);

    for (int k = 0; k < 9; k++) kk[k] = -256;
    kk[4] = 2048;
    push_model(8, 8);
    run_case("checker_signed", 8, 8);

    for (int y = 0; y < mr; y++) for (int x = 0; x < mc; x++) px[y][x] = 32767;
    for (int k = 0; k < 9; k++) kk[k] = 32767;
    for (int s = 0; s < 36; s++) exp_q.push_back(16'h7FFF);
    run_case("sat_pos", 8, 8);
    for (int k = 0; k < 9; k++) kk[k] = -32767;
    for (int s = 0; s < 36; s++) exp_q.push_back(16'h8000);
    run_case("sat_neg", 8, 8);

    for (int y = 0; y < mr; y++)
      for (int x = 0; x < mc; x++) px[y][x] = int'($urandom_range(0, 4095)) - 2048;
    for (int k = 0; k < 9; k++) kk[k] = int'($urandom_range(0, 1023)) - 512;
    push_model(5, 6);
    run_case("random5x6", 5, 6);

    // Abort a run part way through, then confirm a fresh run is clean.
    apply_inputs(8, 8);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort done", 16'(done), 16'd0);
    check("abort out", 16'(filtered_matrix == '0), 16'd1);
    check("abort state", 16'(fsm_state), 16'd0);
    push_model(3, 3);
    run_case("min3x3", 3, 3);

    run_case("rows2", 2, 8);
    run_case("cols9", 8, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
